branch_target_predictor: RTL
============================

Name: branch_target_predictor

Overview:
Parametrised dynamic branch predictor for the pipelined datapath. It replaces fixed "predict not-taken, resolve in ID" behaviour with a direct-mapped branch target buffer (BTB) and per-entry saturating direction counters.
- IF stage: looks up the current PC combinationally and receives a predicted next-PC.
- ID stage: reports resolved branch outcomes through a one-cycle update port.
- Saturating performance counters are included for verification and benchmarking.

Parameters:
PC_W, 16, PC width in bits. The PC is word-addressed, so sequential next-PC is PC+1.
ENTRIES, 16, number of BTB entries. Must be a power of 2 and at least 2. IDX_W = clog2(ENTRIES).
CTR_W, 2, width of the direction counter. Must be at least 1.
STAT_W, 16, width of each statistics counter.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
lookup_pc  in  PC_W  PC currently being fetched in IF
pred_hit  out  1  a valid entry's tag matches lookup_pc
pred_taken  out  1  pred_hit AND counter MSB is 1
pred_target  out  PC_W  stored target when pred_taken, otherwise lookup_pc+1 (mod 2^PC_W)
upd_valid  in  1  an ID-stage resolved branch is reported this cycle
upd_pc  in  PC_W  PC of the resolved branch
upd_taken  in  1  actual branch direction
upd_target  in  PC_W  actual taken target
upd_mispredict  in  1  the IF prediction for this branch was wrong; statistics only
inv_all  in  1  invalidate all entries, e.g. on an instruction-memory reload
stat_updates  out  STAT_W  count of accepted updates, saturating
stat_mispred  out  STAT_W  count of updates with upd_mispredict=1, saturating

Behaviour:
- Storage per entry: valid (1 bit), tag (PC_W-IDX_W bits), target (PC_W bits), ctr (CTR_W bits).
- Addressing: index = pc[IDX_W-1:0]; tag = pc[PC_W-1:IDX_W].
- Lookup:
  - Purely combinational from lookup_pc and the stored state; zero latency.
  - pred_hit = valid[idx] AND (tag[idx] == lookup tag).
  - When pred_hit=0: pred_taken=0 and pred_target=lookup_pc+1.
- Update (registered, takes effect at the edge where upd_valid=1):
  - Hit, upd_taken=1: ctr = min(ctr+1, 2^CTR_W-1); target = upd_target.
  - Hit, upd_taken=0: ctr = max(ctr-1, 0); target unchanged.
  - Miss, upd_taken=1: allocate, overwriting the slot. Set valid=1, tag=upd tag, target=upd_target, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss, upd_taken=0: no allocation; storage unchanged.
- Read-during-write: a lookup in the same cycle as an update to the same index sees the old (pre-edge) contents. There is no bypass.
- inv_all:
  - Clears every valid bit at the next edge.
  - Has priority over a simultaneous upd_valid, whose storage write is dropped.
  - Statistics still count that update.
- Statistics:
  - stat_updates increments on every cycle with upd_valid=1.
  - stat_mispred increments when upd_valid=1 and upd_mispredict=1.
  - Both saturate at 2^STAT_W-1 and do not wrap.
  - upd_mispredict is ignored when upd_valid=0.
- Reset (rst=1 at an edge):
  - Clears all valid bits, all ctr fields and both statistics counters.
  - tag and target fields are don't-care.
  - Overrides inv_all and upd_valid.
  - After reset, every lookup gives pred_hit=0, pred_taken=0, pred_target=lookup_pc+1.
  - Reset asserted mid-training discards all learned state in one cycle.
- Wrap: pred_target for a miss at lookup_pc=2^PC_W-1 is 0.
- No X propagation: outputs are defined for every lookup_pc after the first reset.

Test Plan:
1. Reset, then sweep lookup_pc 0x0000..0x001F -> pred_hit=0, pred_taken=0, pred_target=lookup_pc+1 for every value; stats=0. Also check lookup_pc=0xFFFF -> pred_target=0x0000.
2. Update pc=0x0023, taken=1, target=0x0040. Next cycle lookup 0x0023 -> hit=1, taken=1, target=0x0040, ctr=2. Lookup 0x0013 (same index, different tag) -> hit=0, target=0x0014.
3. Train pc=0x0023 with not-taken twice -> ctr goes 2, 1, 0. After the first not-taken, taken=0 and target=0x0024. Then 4 taken updates -> ctr 1, 2, 3, 3 (saturates). pred_taken=1 from the second of these onward.
4. Aliasing and read-during-write:
   - Entry from scenario 2 is present. Apply a taken update for pc=0x0013 (target 0x0050) while lookup_pc=0x0023 in the same cycle -> that cycle still shows hit=1 and target 0x0040.
   - Next cycle: 0x0023 misses; 0x0013 hits with target 0x0050 and ctr=2.
   - A not-taken update for an absent pc=0x0005 -> no entry is created.
5. inv_all together with a taken update for pc=0x0007 -> next cycle all lookups miss, including 0x0007, and stat_updates increments by 1. Asserting rst while entries are valid clears them the same way.
6. Set STAT_W=4 and issue 20 updates with mispredict=1 on updates 1-3 and on a cycle with upd_valid=0 -> stat_updates=15 (saturated), stat_mispred=3.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. IF looks up the fetch PC combinationally; ID writes resolved
// outcomes through a single-cycle update port. Two saturating statistics
// counters track accepted updates and reported mispredictions.
module branch_target_predictor #(
    parameter int PC_W    = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_mispredict,
    input  logic              inv_all,
    output logic [STAT_W-1:0] stat_updates,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;

    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    // Entry storage
    logic [ENTRIES-1:0] valid_q,  valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [PC_W-1:0]    target_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CTR_W-1:0]   ctr_d    [ENTRIES];

    logic [STAT_W-1:0]  stat_upd_q, stat_upd_d;
    logic [STAT_W-1:0]  stat_mis_q, stat_mis_d;

    // Address split for both ports
    logic [IDX_W-1:0] lk_idx_s, up_idx_s;
    logic [TAG_W-1:0] lk_tag_s, up_tag_s;
    logic             up_hit_s;

    assign lk_idx_s = lookup_pc[IDX_W-1:0];
    assign lk_tag_s = lookup_pc[PC_W-1:IDX_W];
    assign up_idx_s = upd_pc[IDX_W-1:0];
    assign up_tag_s = upd_pc[PC_W-1:IDX_W];
    assign up_hit_s = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);

    // Lookup: reads only registered state, so a same-cycle update is not visible
    always_comb begin
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = lookup_pc + PC_W'(1);
        if (valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s)) begin
            pred_hit   = 1'b1;
            pred_taken = ctr_q[lk_idx_s][CTR_W-1];
            if (ctr_q[lk_idx_s][CTR_W-1]) begin
                pred_target = target_q[lk_idx_s];
            end else begin
                pred_target = lookup_pc + PC_W'(1);
            end
        end else begin
            pred_hit = 1'b0;
        end
    end

    // Entry next-state: invalidate-all beats a simultaneous update
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (inv_all) begin
            valid_d = '0;
        end else if (upd_valid) begin
            if (up_hit_s) begin
                if (upd_taken) begin
                    target_d[up_idx_s] = upd_target;
                    if (ctr_q[up_idx_s] != CTR_MAX) begin
                        ctr_d[up_idx_s] = ctr_q[up_idx_s] + CTR_W'(1);
                    end else begin
                        ctr_d[up_idx_s] = ctr_q[up_idx_s];
                    end
                end else begin
                    if (ctr_q[up_idx_s] != '0) begin
                        ctr_d[up_idx_s] = ctr_q[up_idx_s] - CTR_W'(1);
                    end else begin
                        ctr_d[up_idx_s] = ctr_q[up_idx_s];
                    end
                end
            end else if (upd_taken) begin
                // Allocate on a taken miss, evicting whatever aliased here
                valid_d[up_idx_s]  = 1'b1;
                tag_d[up_idx_s]    = up_tag_s;
                target_d[up_idx_s] = upd_target;
                ctr_d[up_idx_s]    = CTR_WEAK;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Statistics next-state: saturating, mispredict qualified by upd_valid
    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (upd_valid && (stat_upd_q != STAT_MAX)) begin
            stat_upd_d = stat_upd_q + STAT_W'(1);
        end else begin
            stat_upd_d = stat_upd_q;
        end
        if (upd_valid && upd_mispredict && (stat_mis_q != STAT_MAX)) begin
            stat_mis_d = stat_mis_q + STAT_W'(1);
        end else begin
            stat_mis_d = stat_mis_q;
        end
    end

    // State registers; reset clears all learned state and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            stat_upd_q <= '0;
            stat_mis_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_updates = stat_upd_q;
    assign stat_mispred = stat_mis_q;

endmodule
